fir_mac_scheduler: RTL and testbench

Sequencer that time-shares one multiply-accumulate (MAC) unit and one sample-history RAM across all FIR filters and both audio channels. It sits between the interpolator output strobes and the FIR datapath. It arbitrates left/right sample requests, writes each new sample into the circular history, and issues per-tap RAM addresses. It also emits pipeline-aligned MAC controls and per-channel completion strobes toward the equalizer stage.

---
 rtl/audio_pkg.sv | 17 +
 rtl/ctrl_delay_line.sv | 29 ++
 rtl/fir_mac_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_fir_mac_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared FSM state, sample width and channel encoding for the FIR path
package audio_pkg;

  localparam int SAMPLE_W = 24;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/ctrl_delay_line.sv
// rtl/ctrl_delay_line.sv - fixed-depth shift register aligning MAC control tags with RAM/multiplier latency
module ctrl_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_stage [DEPTH];

  // Advance tags one stage per cycle; clr flushes everything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q = r_stage[DEPTH-1];

endmodule

// File: rtl/fir_mac_scheduler.sv
// rtl/fir_mac_scheduler.sv - time-shares one MAC and one history RAM across all filters and both channels
module fir_mac_scheduler
  import audio_pkg::*;
#(
  parameter int  NUM_FILTERS = 4,
  parameter int  TAP_W       = 8,
  parameter int  PIPE_LAT    = 3,
  localparam int FW          = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic [TAP_W-1:0]    taps_per_filter,
  input  logic                l_data_en,
  input  logic                r_data_en,
  input  logic [SAMPLE_W-1:0] l_data_in,
  input  logic [SAMPLE_W-1:0] r_data_in,
  output logic                hist_we,
  output logic [SAMPLE_W-1:0] hist_wr_data,
  output logic                hist_ch,
  output logic [TAP_W-1:0]    hist_addr,
  output logic [FW+TAP_W-1:0] coef_addr,
  output logic                mac_en,
  output logic                mac_clr,
  output logic                acc_store,
  output logic [FW-1:0]       acc_filt,
  output logic                acc_ch,
  output logic                l_data_valid,
  output logic                r_data_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int CW = 3 + FW + 1;

  sched_state_t        r_state, w_next;
  logic [1:0]          r_pend;
  logic [SAMPLE_W-1:0] r_pend_data [2];
  logic [TAP_W-1:0]    r_head [2];
  logic                r_ch;
  logic [SAMPLE_W-1:0] r_sample;
  logic [TAP_W-1:0]    r_n;
  logic [TAP_W-1:0]    r_base;
  logic [TAP_W-1:0]    r_k;
  logic [FW-1:0]       r_f;
  logic [DW-1:0]       r_drain;
  logic                r_overrun;

  logic [1:0]          w_en;
  logic [SAMPLE_W-1:0] w_din [2];
  logic                w_accept;
  logic                w_sel;
  logic                w_last_k;
  logic                w_last_f;
  logic                w_drain_end;
  logic                w_issue;
  logic                w_first;
  logic                w_last;
  logic [CW-1:0]       w_ctrl_in;
  logic [CW-1:0]       w_ctrl_out;

  assign w_en        = {r_data_en, l_data_en};
  assign w_din[0]    = l_data_in;
  assign w_din[1]    = r_data_in;
  assign w_accept    = run && (r_state == ST_IDLE) && (r_pend != 2'b00);
  assign w_sel       = r_pend[CH_L] ? CH_L : CH_R;
  // N == 0 encodes 2^TAP_W taps: N-1 then wraps to the all-ones tap index.
  assign w_last_k    = (r_k == r_n - TAP_W'(1));
  assign w_last_f    = (r_f == FW'(NUM_FILTERS - 1));
  assign w_drain_end = (r_drain == DW'(PIPE_LAT - 1));
  assign w_issue     = (r_state == ST_ISSUE);
  assign w_first     = w_issue && (r_k == '0);
  assign w_last      = w_issue && w_last_k;

  // Per-channel pending capture; a strobe on an unaccepted pending slot is dropped and flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend         <= '0;
      r_pend_data[0] <= '0;
      r_pend_data[1] <= '0;
      r_overrun      <= 1'b0;
    end else if (!run) begin
      r_pend    <= '0;
      r_overrun <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (w_en[c]) begin
          if (r_pend[c] && !(w_accept && (int'(w_sel) == c))) begin
            r_overrun <= 1'b1;
          end else begin
            r_pend[c]      <= 1'b1;
            r_pend_data[c] <= w_din[c];
          end
        end else if (w_accept && (int'(w_sel) == c)) begin
          r_pend[c] <= 1'b0;
        end
      end
    end
  end

  // Sample/N latch at accept, head advance at write, slot and drain counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head[0] <= '0;
      r_head[1] <= '0;
      r_ch      <= CH_L;
      r_sample  <= '0;
      r_n       <= '0;
      r_base    <= '0;
      r_k       <= '0;
      r_f       <= '0;
      r_drain   <= '0;
    end else if (!run) begin
      r_head[0] <= '0;
      r_head[1] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ch     <= w_sel;
            r_sample <= r_pend_data[w_sel];
            r_n      <= taps_per_filter;
          end
        end
        ST_WRITE: begin
          r_base         <= r_head[r_ch];
          r_head[r_ch]   <= r_head[r_ch] + TAP_W'(1);
          r_k            <= '0;
          r_f            <= '0;
        end
        ST_ISSUE: begin
          r_drain <= '0;
          if (w_last_k) begin
            r_k <= '0;
            r_f <= r_f + FW'(1);
          end else begin
            r_k <= r_k + TAP_W'(1);
          end
        end
        ST_DRAIN: r_drain <= r_drain + DW'(1);
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode; run low forces a return to IDLE on the next cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_WRITE;
      ST_WRITE: w_next = ST_ISSUE;
      ST_ISSUE: if (w_last_k && w_last_f) w_next = ST_DRAIN;
      ST_DRAIN: if (w_drain_end) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (!run) w_next = ST_IDLE;
  end

  // History/coefficient addressing and completion strobes decoded from the current state.
  always_comb begin
    hist_we      = 1'b0;
    hist_wr_data = '0;
    hist_ch      = 1'b0;
    hist_addr    = '0;
    coef_addr    = '0;
    l_data_valid = 1'b0;
    r_data_valid = 1'b0;
    case (r_state)
      ST_WRITE: begin
        hist_we      = 1'b1;
        hist_wr_data = r_sample;
        hist_ch      = r_ch;
        hist_addr    = r_head[r_ch];
      end
      ST_ISSUE: begin
        hist_ch   = r_ch;
        hist_addr = r_base - r_k;
        coef_addr = {r_f, r_k};
      end
      ST_DONE: begin
        l_data_valid = (r_ch == CH_L);
        r_data_valid = (r_ch == CH_R);
      end
      default: ;
    endcase
  end

  assign busy    = (r_state != ST_IDLE);
  assign overrun = r_overrun;

  assign w_ctrl_in = {w_issue, w_first, w_last, (w_issue ? r_f : FW'(0)), (w_issue & r_ch)};

  ctrl_delay_line #(
    .W     (CW),
    .DEPTH (PIPE_LAT)
  ) u_ctrl_dl (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!run),
    .d       (w_ctrl_in),
    .q       (w_ctrl_out)
  );

  assign mac_en    = w_ctrl_out[CW-1];
  assign mac_clr   = w_ctrl_out[CW-2];
  assign acc_store = w_ctrl_out[CW-3];
  assign acc_filt  = w_ctrl_out[FW:1];
  assign acc_ch    = w_ctrl_out[0];

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb/tb_fir_mac_scheduler.sv - scoreboard bench for fir_mac_scheduler with a cycle-stamped reference model
module tb_fir_mac_scheduler;

  localparam int F  = 4;
  localparam int PL = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  taps = 8'd0;
  logic        l_en = 1'b0, r_en = 1'b0;
  logic [23:0] l_in = '0, r_in = '0;

  logic        hist_we, hist_ch, mac_en, mac_clr, acc_store, acc_ch;
  logic        l_data_valid, r_data_valid, busy, overrun;
  logic [23:0] hist_wr_data;
  logic [7:0]  hist_addr;
  logic [9:0]  coef_addr;
  logic [1:0]  acc_filt;

  fir_mac_scheduler #(.NUM_FILTERS(F), .TAP_W(8), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .taps_per_filter(taps),
    .l_data_en(l_en), .r_data_en(r_en), .l_data_in(l_in), .r_data_in(r_in),
    .hist_we(hist_we), .hist_wr_data(hist_wr_data), .hist_ch(hist_ch), .hist_addr(hist_addr),
    .coef_addr(coef_addr), .mac_en(mac_en), .mac_clr(mac_clr), .acc_store(acc_store),
    .acc_filt(acc_filt), .acc_ch(acc_ch), .l_data_valid(l_data_valid), .r_data_valid(r_data_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, got, exp);
    end
  endtask

  task automatic fail(input string name, input string got, input string req);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d: got %s, required %s", name, cyc, got, req);
  endtask

  // Expected events, each stamped with the cycle it must appear in.
  typedef struct { int cyc; logic ch; logic [7:0] addr; logic [23:0] data; } wr_t;
  typedef struct { int cyc; logic [7:0] addr; logic [9:0] coef; logic clr; logic st; logic [1:0] filt; logic ch; } mac_t;
  typedef struct { int cyc; logic ch; } val_t;
  wr_t  wq[$];
  mac_t mq[$];
  val_t vq[$];

  // Reference model state.
  bit          m_pend [2];
  logic [23:0] m_pdata [2];
  logic [7:0]  m_head [2];
  bit          m_ovr = 0, m_ovr_cur = 0, m_busy_cur = 0;
  int          m_busy_from = 1, m_busy_to = 0, m_free = 0;

  task automatic schedule(input int t, input logic ch);
    int n;
    logic [7:0] base;
    n    = (taps == 8'd0) ? 256 : int'(taps);
    base = m_head[ch];
    wq.push_back('{t + 1, ch, base, m_pdata[ch]});
    m_head[ch] = base + 8'd1;
    for (int f = 0; f < F; f++)
      for (int k = 0; k < n; k++)
        mq.push_back('{t + 2 + f * n + k + PL, base - 8'(k), {2'(f), 8'(k)},
                       (k == 0), (k == n - 1), 2'(f), ch});
    vq.push_back('{t + 2 + F * n + PL, ch});
    m_busy_from = t + 1;
    m_busy_to   = t + 2 + F * n + PL;
    m_free      = t + 3 + F * n + PL;
  endtask

  task automatic model_step(input int s);
    logic [1:0] en;
    m_busy_cur = (s >= m_busy_from) && (s <= m_busy_to);
    m_ovr_cur  = m_ovr;
    if (!run) begin
      m_pend[0] = 0; m_pend[1] = 0;
      m_head[0] = '0; m_head[1] = '0;
      m_ovr = 0;
      while (wq.size() > 0 && wq[$].cyc > s) void'(wq.pop_back());
      while (mq.size() > 0 && mq[$].cyc > s) void'(mq.pop_back());
      while (vq.size() > 0 && vq[$].cyc > s) void'(vq.pop_back());
      if (m_busy_to > s) m_busy_to = s;
      m_free = s + 1;
    end else begin
      if (s >= m_free && (m_pend[0] || m_pend[1])) begin
        if (m_pend[0]) begin m_pend[0] = 0; schedule(s, 1'b0); end
        else begin m_pend[1] = 0; schedule(s, 1'b1); end
      end
      en = {r_en, l_en};
      for (int c = 0; c < 2; c++) begin
        if (en[c]) begin
          if (m_pend[c]) m_ovr = 1;
          else begin
            m_pend[c]  = 1;
            m_pdata[c] = (c == 0) ? l_in : r_in;
          end
        end
      end
    end
  endtask

  // Monitor: consumes expected events whenever the DUT presents one.
  logic [7:0] h_addr_hist [16];
  logic [9:0] coef_hist [16];
  logic       ch_hist [16];
  bit         mon_on = 0;
  int         mac_cnt = 0;
  logic [7:0] last_wr_addr = '0;

  always @(negedge clk) begin
    int   s;
    int   i;
    wr_t  we;
    mac_t me;
    val_t ve;
    if (mon_on) begin
      s = cyc;
      h_addr_hist[s % 16] = hist_addr;
      coef_hist[s % 16]   = coef_addr;
      ch_hist[s % 16]     = hist_ch;
      while (wq.size() > 0 && wq[0].cyc < s) begin check("wr_missing", 64'(s), 64'(wq[0].cyc)); void'(wq.pop_front()); end
      while (mq.size() > 0 && mq[0].cyc < s) begin check("mac_missing", 64'(s), 64'(mq[0].cyc)); void'(mq.pop_front()); end
      while (vq.size() > 0 && vq[0].cyc < s) begin check("valid_missing", 64'(s), 64'(vq[0].cyc)); void'(vq.pop_front()); end
      if (hist_we) begin
        last_wr_addr = hist_addr;
        if (wq.size() == 0) fail("wr_unexpected", "hist_we=1", "no write");
        else begin
          we = wq.pop_front();
          check("hist_write", 64'({16'(s), hist_ch, hist_addr, hist_wr_data}),
                64'({16'(we.cyc), we.ch, we.addr, we.data}));
        end
      end
      if (mac_en) begin
        mac_cnt++;
        if (mq.size() == 0) fail("mac_unexpected", "mac_en=1", "no mac");
        else begin
          me = mq.pop_front();
          i  = (s - PL) % 16;
          check("mac_slot", 64'({16'(s), h_addr_hist[i], coef_hist[i], ch_hist[i], mac_clr, acc_store, acc_filt, acc_ch}),
                64'({16'(me.cyc), me.addr, me.coef, me.ch, me.clr, me.st, me.filt, me.ch}));
        end
      end else if (mac_clr || acc_store) begin
        fail("ctrl_without_mac", "mac_clr/acc_store high", "low without mac_en");
      end
      if (l_data_valid) begin
        if (vq.size() == 0) fail("l_valid_unexpected", "l_data_valid=1", "no valid");
        else begin ve = vq.pop_front(); check("l_valid", 64'({16'(s), 1'b0}), 64'({16'(ve.cyc), ve.ch})); end
      end
      if (r_data_valid) begin
        if (vq.size() == 0) fail("r_valid_unexpected", "r_data_valid=1", "no valid");
        else begin ve = vq.pop_front(); check("r_valid", 64'({16'(s), 1'b1}), 64'({16'(ve.cyc), ve.ch})); end
      end
      check("busy", 64'(busy), 64'(m_busy_cur));
      check("overrun", 64'(overrun), 64'(m_ovr_cur));
    end
  end

  // Driver: inputs change 2 time units after the active edge, then the model takes the same cycle.
  logic [7:0] cur_taps = 8'd8;

  task automatic step(input bit rv, input bit le, input bit re, input logic [23:0] ld, input logic [23:0] rd);
    @(posedge clk);
    #2;
    run = rv; l_en = le; r_en = re; l_in = ld; r_in = rd; taps = cur_taps;
    model_step(cyc);
    mon_on = 1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      idle();
      if (!busy && !m_pend[0] && !m_pend[1] && vq.size() == 0) break;
    end
    if (i >= budget) fail(name, "still busy", "idle within budget");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    m_pend[0] = 0; m_pend[1] = 0;
    m_head[0] = '0; m_head[1] = '0;
    m_pdata[0] = '0; m_pdata[1] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          64'({hist_we, hist_wr_data, hist_ch, hist_addr, coef_addr, mac_en, mac_clr, acc_store,
               acc_filt, acc_ch, l_data_valid, r_data_valid, busy, overrun}), 64'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    cur_taps = 8'd8;
    repeat (3) idle();

    // Single left sample.
    step(1'b1, 1'b1, 1'b0, 24'h123456, 24'h0);
    wait_idle("single_l_timeout", 200);

    // Simultaneous strobes: left first, no overrun.
    step(1'b1, 1'b1, 1'b1, 24'($urandom), 24'($urandom));
    wait_idle("tie_timeout", 400);
    check("tie_no_overrun", 64'(overrun), 64'd0);

    // Burst on left while busy: second pends, later ones are dropped.
    step(1'b1, 1'b1, 1'b0, 24'hA00001, 24'h0);
    idle();
    step(1'b1, 1'b1, 1'b0, 24'hA00002, 24'h0);
    idle();
    step(1'b1, 1'b1, 1'b0, 24'hA00003, 24'h0);
    idle();
    step(1'b1, 1'b1, 1'b0, 24'hA00004, 24'h0);
    idle();
    check("burst_overrun", 64'(overrun), 64'd1);
    wait_idle("burst_timeout", 600);

    // Full 256-tap filters.
    cur_taps = 8'd0;
    c0 = mac_cnt;
    step(1'b1, 1'b1, 1'b0, 24'($urandom), 24'h0);
    wait_idle("taps256_timeout", 1300);
    check("mac_count_256", 64'(mac_cnt - c0), 64'd1024);

    // Abort during ISSUE with an overrun outstanding.
    cur_taps = 8'd8;
    step(1'b1, 1'b0, 1'b1, 24'h0, 24'($urandom));
    idle();
    step(1'b1, 1'b0, 1'b1, 24'h0, 24'($urandom));
    idle();
    step(1'b1, 1'b0, 1'b1, 24'h0, 24'($urandom));
    repeat (6) idle();
    step(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
    idle();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_mac_en", 64'(mac_en), 64'd0);
    check("abort_overrun", 64'(overrun), 64'd0);
    repeat (50) idle();

    // Right channel: 258 writes from head 0, last one lands at address 1.
    cur_taps = 8'd1;
    for (int n = 0; n < 258; n++) begin
      step(1'b1, 1'b0, 1'b1, 24'h0, 24'($urandom));
      wait_idle("wrap_timeout", 40);
    end
    check("head_wrap_addr", 64'(last_wr_addr), 64'd1);

    // Randomized traffic with occasional run drops.
    for (int n = 0; n < 1500; n++) begin
      cur_taps = 8'($urandom_range(1, 6));
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0),
           24'($urandom), 24'($urandom));
    end
    wait_idle("random_timeout", 2000);
    repeat (5) idle();

    check("wr_queue_empty", 64'(wq.size()), 64'd0);
    check("mac_queue_empty", 64'(mq.size()), 64'd0);
    check("valid_queue_empty", 64'(vq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
